// File: rtl/wash_phase_timer.sv
// wash_phase_timer: times each one-hot washer phase against its programmed
// duration and holds the matching timer_* level once the phase has expired.
module wash_phase_timer #(
    parameter int CNT_W       = 16,
    parameter int PRESCALE    = 1000,
    parameter int SOAK_LOW_T  = 5,
    parameter int SOAK_HIGH_T = 10,
    parameter int WASH_LOW_T  = 8,
    parameter int WASH_HIGH_T = 15,
    parameter int RINSE_T     = 6,
    parameter int SPIN_T      = 4,
    parameter int DRAIN_T     = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             idle,
    input  logic             soak_low,
    input  logic             soak_high,
    input  logic             wash_low,
    input  logic             wash_high,
    input  logic             rinse,
    input  logic             spin,
    input  logic             drain,
    input  logic             stop,
    output logic             timer_soak_low,
    output logic             timer_soak_high,
    output logic             timer_wash_low,
    output logic             timer_wash_high,
    output logic             timer_rinse,
    output logic             timer_spin,
    output logic             timer_drain,
    output logic [CNT_W-1:0] remaining,
    output logic             busy,
    output logic             phase_err
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE, ERR} state_t;

    state_t           state;
    logic [6:0]       p, prev_p, tmr;
    logic [PW-1:0]    presc;
    logic [CNT_W-1:0] dur;
    logic             err, none, load;

    assign p    = {soak_low, soak_high, wash_low, wash_high, rinse, spin, drain};
    assign err  = ((p & (p - 7'd1)) != 7'd0) | (idle & (|p));
    assign none = idle | (p == 7'd0);
    // Leaving IDLE or ERR on a one-hot vector always loads, even if P matches prev_p.
    assign load = (p != prev_p) | (state == IDLE) | (state == ERR);
    assign {timer_soak_low, timer_soak_high, timer_wash_low, timer_wash_high,
            timer_rinse, timer_spin, timer_drain} = tmr;

    always_comb begin
        dur = p[6] ? CNT_W'(SOAK_LOW_T)  :
              p[5] ? CNT_W'(SOAK_HIGH_T) :
              p[4] ? CNT_W'(WASH_LOW_T)  :
              p[3] ? CNT_W'(WASH_HIGH_T) :
              p[2] ? CNT_W'(RINSE_T)     :
              p[1] ? CNT_W'(SPIN_T)      : CNT_W'(DRAIN_T);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            prev_p    <= '0;
            presc     <= '0;
            remaining <= '0;
            tmr       <= '0;
            busy      <= 1'b0;
            phase_err <= 1'b0;
        end else begin
            prev_p <= p;
            if (err) begin
                state     <= ERR;
                tmr       <= '0;
                busy      <= 1'b0;
                phase_err <= 1'b1;
            end else if (none) begin
                state     <= IDLE;
                presc     <= '0;
                remaining <= '0;
                tmr       <= '0;
                busy      <= 1'b0;
                phase_err <= 1'b0;
            end else if (load) begin
                state     <= RUN;
                remaining <= dur;
                presc     <= '0;
                tmr       <= '0;
                busy      <= 1'b1;
                phase_err <= 1'b0;
            end else if (state == RUN) begin
                if (remaining == '0) begin
                    state <= DONE;
                    tmr   <= p;
                    busy  <= 1'b0;
                end else if (!stop) begin
                    presc <= (presc == PMAX) ? '0 : presc + 1'b1;
                    if (presc == PMAX) remaining <= remaining - 1'b1;
                end
            end
        end
    end
endmodule

// File: doc/wash_phase_timer.md
# wash_phase_timer

Phase-duration scheduler for the washing-machine controller. It watches the controller's one-hot phase outputs and times each phase against a programmed duration. When the duration expires, it raises the matching `timer_*` completion input back to the controller. It sits between the system clock and the washing-machine FSM, and replaces the bench-driven timer stimulus with real cycle-counted timing.

## Interface
Parameters:
- `CNT_W`, 16: width of the remaining-time counter and all duration parameters.
- `PRESCALE`, 1000: clock cycles per time unit; must be ≥ 1.
- `SOAK_LOW_T`, 5: soak_low duration in time units.
- `SOAK_HIGH_T`, 10: soak_high duration in time units.
- `WASH_LOW_T`, 8: wash_low duration in time units.
- `WASH_HIGH_T`, 15: wash_high duration in time units.
- `RINSE_T`, 6: rinse duration in time units.
- `SPIN_T`, 4: spin duration in time units.
- `DRAIN_T`, 3: drain duration in time units.

Ports:
- `clk` in 1: system clock; rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `idle`, `soak_low`, `soak_high`, `wash_low`, `wash_high`, `rinse`, `spin`, `drain` in 1 each: phase outputs of the washing-machine FSM; expected one-hot or all-zero.
- `stop` in 1: pause; freezes timing while high.
- `timer_soak_low`, `timer_soak_high`, `timer_wash_low`, `timer_wash_high`, `timer_rinse`, `timer_spin`, `timer_drain` out 1 each: phase-complete levels to the FSM.
- `remaining` out CNT_W: time units left in the current phase.
- `busy` out 1: high in RUN.
- `phase_err` out 1: high while the phase vector is not one-hot and not all-zero.

## Operation
- Phase vector P = {soak_low, soak_high, wash_low, wash_high, rinse, spin, drain}. `idle` high, or P all-zero, means "no timed phase".
- Registered copy `prev_P` holds P from the previous edge.
- Internal state machine: IDLE, RUN, DONE, ERR.
- **IDLE**
  - All `timer_*` = 0, `remaining` = 0.
  - P one-hot and `idle` = 0 → load, go RUN.
- **Load** (on any edge where P is one-hot, `idle` = 0 and P ≠ `prev_P`, from any state):
  - `remaining` ← that phase's duration parameter.
  - Prescaler ← 0.
  - All `timer_*` ← 0.
  - State ← RUN.
- **RUN**
  - If `remaining` = 0 → DONE.
  - Else, if `stop` = 0: prescaler increments; at PRESCALE−1 it wraps to 0 and `remaining` decrements by 1.
  - `stop` = 1 freezes both the prescaler and `remaining`.
- **DONE**
  - The `timer_*` bit matching the active phase is high; all others are 0.
  - The bit is held as a level until P changes. It is not a pulse; the FSM may take any number of cycles to respond.
  - `stop` has no effect in DONE.
- **Return to IDLE:** `idle` = 1 or P all-zero, from any state → IDLE on the next edge; all timers clear.
- **ERR**
  - Entered when P has two or more bits set, or `idle` = 1 together with any P bit.
  - `phase_err` = 1, timers 0, `remaining` held.
  - Leaves only on a valid one-hot P (→ load) or on the no-phase condition (→ IDLE).
- **Priority** (highest first): reset, ERR condition, no-phase condition, load, RUN/DONE behaviour.
- **Same-phase reentry:** P unchanged after DONE keeps DONE. A change to a different phase and back reloads.
- **Arithmetic:** `remaining` never underflows. Durations are truncated to CNT_W bits.

## Timing
- Reset values:
  - state IDLE;
  - `prev_P` = 0;
  - prescaler = 0, `remaining` = 0;
  - all `timer_*` = 0, `busy` = 0, `phase_err` = 0.
- Outputs are registered; no combinational path from inputs to outputs.
- Latency: with load at edge L and `stop` held low, the timer bit rises after edge L + D·PRESCALE + 1, where D is the phase duration. D = 0 gives the timer at edge L+1.
- Each stop-high cycle during RUN adds exactly one cycle of latency.
- A phase change during RUN or DONE reloads on that same edge; the old timer drops at that edge.
- `stop` high on a load edge: the load still happens, then counting stays frozen.
- Reset asserted mid-phase: all state clears immediately. After release, the current P is treated as a new phase (`prev_P` = 0) and loads on the first edge.

## Test plan
Bench parameters for all scenarios: PRESCALE = 4, SOAK_HIGH_T = 3, WASH_HIGH_T = 2, DRAIN_T = 0.

1. `rst` low→high with `idle` = 1, then `soak_high` = 1 → `busy` rises the next edge, `remaining` = 3; `timer_soak_high` rises 13 edges after load and stays high until `soak_high` falls.
2. `wash_high` active, `stop` held high for 5 cycles mid-count → `timer_wash_high` rises at load + 9 + 5 edges; `remaining` is frozen during the stop cycles.
3. `drain` active (DRAIN_T = 0) → `timer_drain` high 1 edge after load, `remaining` = 0.
4. `soak_high` switches to `wash_high` while `remaining` = 2 → on that edge `remaining` = 2 from the new load, `timer_soak_high` stays 0, and `timer_wash_high` rises 9 edges later.
5. `soak_low` and `rinse` both high → `phase_err` = 1 and all timers 0; then `rinse` alone → `phase_err` = 0, load RINSE_T.
6. `rst` pulsed low during RUN with `spin` high → all outputs 0 immediately; after release, SPIN_T reloads on the first edge and `timer_spin` rises at SPIN_T·4 + 1 edges.
